// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the sync generator and the pixel pipeline.
// qFRAME exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
   parameter int CW = 12,
   parameter int FW = 16
);
   logic          CE;
   logic [CW-1:0] qX;
   logic [CW-1:0] qY;
   logic          DE;
   logic          HSYNC;
   logic          VSYNC;
   logic          SOL;
   logic          SOF;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FW-1:0] qFRAME;
`endif

   if (CW < 1 || FW < 1) begin : g_width_chk
      $error("vga_timing_gen_if: CW and FW must be at least 1");
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   modport master (input CE, output qX, qY, DE, HSYNC, VSYNC, SOL, SOF, qFRAME);
   modport slave  (output CE, input qX, qY, DE, HSYNC, VSYNC, SOL, SOF, qFRAME);
`else
   modport master (input CE, output qX, qY, DE, HSYNC, VSYNC, SOL, SOF);
   modport slave  (output CE, input qX, qY, DE, HSYNC, VSYNC, SOL, SOF);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, sync, data-enable and line/frame strobes.
// Optional frame counter on qFRAME when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
   parameter int CW       = 12,
   parameter int H_ACTIVE = 800,
   parameter int H_FRONT  = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BACK   = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FRONT  = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BACK   = 23,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int FW       = 16
) (
   input  logic              CLK,
   input  logic              RSTn,
   vga_timing_gen_if.master  vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam longint CW_MAX = (longint'(1) << CW) - 1;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FRONT);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FRONT);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

   if (longint'(H_TOTAL - 1) > CW_MAX || longint'(V_TOTAL - 1) > CW_MAX || FW < 1) begin : g_cw_chk
      $error("vga_timing_gen: CW=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d", CW, H_TOTAL - 1, V_TOTAL - 1);
   end
   if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_mode_chk
      $error("vga_timing_gen: sync and active widths must be at least 1");
   end

   // Half-open window test shared by both sync generators
   function automatic logic in_window(input logic [CW-1:0] pos,
                                      input logic [CW-1:0] lo,
                                      input logic [CW-1:0] hi);
      return (pos >= lo) && (pos < hi);
   endfunction

   logic [CW-1:0] x_nxt, y_nxt;
   logic          de_nxt, hs_nxt, vs_nxt;

   logic [CW-1:0] x_p0, y_p0;
   logic          de_p0, hs_p0, vs_p0, sol_p0, sof_p0;

   // Next position and the outputs describing it, so everything lands in one register stage
   always_comb begin
      x_nxt = x_p0 + CW'(1);
      y_nxt = y_p0;
      if (x_p0 == H_LAST) begin
         x_nxt = '0;
         y_nxt = (y_p0 == V_LAST) ? '0 : y_p0 + CW'(1);
      end
      de_nxt = (x_nxt < H_ACT) && (y_nxt < V_ACT);
      hs_nxt = in_window(x_nxt, HS_BEG, HS_END) ? HS_POL : ~HS_POL;
      vs_nxt = in_window(y_nxt, VS_BEG, VS_END) ? VS_POL : ~VS_POL;
   end

   // Stage p0: registered raster state
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         x_p0   <= H_LAST;
         y_p0   <= V_LAST;
         de_p0  <= 1'b0;
         hs_p0  <= ~HS_POL;
         vs_p0  <= ~VS_POL;
         sol_p0 <= 1'b0;
         sof_p0 <= 1'b0;
      end else begin
         sol_p0 <= 1'b0;
         sof_p0 <= 1'b0;
         if (vga.CE) begin
            x_p0   <= x_nxt;
            y_p0   <= y_nxt;
            de_p0  <= de_nxt;
            hs_p0  <= hs_nxt;
            vs_p0  <= vs_nxt;
            sol_p0 <= (x_nxt == '0);
            sof_p0 <= (x_nxt == '0) && (y_nxt == '0);
         end
      end
   end

   assign vga.qX    = x_p0;
   assign vga.qY    = y_p0;
   assign vga.DE    = de_p0;
   assign vga.HSYNC = hs_p0;
   assign vga.VSYNC = vs_p0;
   assign vga.SOL   = sol_p0;
   assign vga.SOF   = sof_p0;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FW-1:0] frame_p0;

   // Counts in the same edge that raises SOF, so the first frame reads 1
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         frame_p0 <= '0;
      end else if (vga.CE && (x_nxt == '0) && (y_nxt == '0)) begin
         frame_p0 <= frame_p0 + FW'(1);
      end
   end

   assign vga.qFRAME = frame_p0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 mode, 640x480 negative-polarity mode, and a tiny mode for frame-level timing.
module tb_vga_timing_gen;
   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 CLK = ~CLK;

   vga_timing_gen_if #(.CW(12), .FW(16)) ifa ();
   vga_timing_gen_if #(.CW(12), .FW(16)) ifb ();
   vga_timing_gen_if #(.CW(4),  .FW(3))  ifc ();

   vga_timing_gen #(.CW(12)) dut_a (.CLK(CLK), .RSTn(RSTn), .vga(ifa));

   vga_timing_gen #(
      .CW(12), .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
      .V_ACTIVE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
      .HS_POL(1'b0), .VS_POL(1'b0), .FW(16)
   ) dut_b (.CLK(CLK), .RSTn(RSTn), .vga(ifb));

   vga_timing_gen #(
      .CW(4), .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .FW(3)
   ) dut_c (.CLK(CLK), .RSTn(RSTn), .vga(ifc));

   typedef struct {
      logic rstn;
      logic ce;
      int   x;
      int   y;
      logic de;
      logic hs;
      logic vs;
      logic sol;
      logic sof;
   } vec_t;

   vec_t tbl [11];

   task automatic set_in(input logic r, input logic c);
      RSTn   = r;
      ifa.CE = c;
      ifb.CE = c;
      ifc.CE = c;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic do_reset();
      set_in(1'b0, 1'b1);
      step();
      step();
   endtask

   initial begin
      logic [28:0] act_v, exp_v;
      int hs_cnt, hs_min, hs_max, de_cnt, sol_n, sol_i0, sol_i1;
      int bhs_cnt, bhs_min, bhs_max;
      int rise_n, rise0, rise1, strobe_viol;
      logic prev_hs, prev_sol, prev_sof;
      int vs_bad, vs_cnt, vs_chg_viol, sof_n, sof_i0, sof_i1, cde_cnt;
      logic prev_vs;
      logic [3:0] prev_y;

      // rstn ce   x     y    de    hs    vs    sol   sof
      tbl[0]  = '{1'b0, 1'b1, 1055, 627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1055, 627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1055, 627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 0,    0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 0,    0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1,    0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1,    0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 2,    0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1055, 627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1055, 627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 0,    0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

      set_in(1'b0, 1'b0);
      for (int k = 0; k < 11; k++) begin
         set_in(tbl[k].rstn, tbl[k].ce);
         step();
         act_v = {ifa.qX, ifa.qY, ifa.DE, ifa.HSYNC, ifa.VSYNC, ifa.SOL, ifa.SOF};
         exp_v = {12'(tbl[k].x), 12'(tbl[k].y), tbl[k].de, tbl[k].hs, tbl[k].vs, tbl[k].sol, tbl[k].sof};
         chk($sformatf("vec%0d", k), longint'(act_v), longint'(exp_v));
      end

      // Reset state of the other two modes
      do_reset();
      chk("b_reset", longint'({ifb.qX, ifb.qY, ifb.DE, ifb.HSYNC, ifb.VSYNC}),
          longint'({12'd799, 12'd524, 1'b0, 1'b1, 1'b1}));
      chk("c_reset", longint'({ifc.qX, ifc.qY, ifc.DE, ifc.HSYNC, ifc.VSYNC}),
          longint'({4'd7, 4'd6, 1'b0, 1'b0, 1'b1}));

      // Two lines of continuous CE: horizontal timing of modes a and b
      hs_cnt = 0; hs_min = 9999; hs_max = -1; de_cnt = 0; sol_n = 0; sol_i0 = -1; sol_i1 = -1;
      bhs_cnt = 0; bhs_min = 9999; bhs_max = -1;
      set_in(1'b1, 1'b1);
      for (int i = 0; i < 2112; i++) begin
         step();
         if (i < 1056) begin
            if (ifa.HSYNC) begin
               hs_cnt++;
               if (int'(ifa.qX) < hs_min) hs_min = int'(ifa.qX);
               if (int'(ifa.qX) > hs_max) hs_max = int'(ifa.qX);
            end
            if (ifa.DE) de_cnt++;
         end
         if (ifa.SOL) begin
            if (sol_n == 0) sol_i0 = i;
            if (sol_n == 1) sol_i1 = i;
            sol_n++;
         end
         if (i < 800 && !ifb.HSYNC) begin
            bhs_cnt++;
            if (int'(ifb.qX) < bhs_min) bhs_min = int'(ifb.qX);
            if (int'(ifb.qX) > bhs_max) bhs_max = int'(ifb.qX);
         end
      end
      chk("a_hs_width", hs_cnt, 128);
      chk("a_hs_first", hs_min, 840);
      chk("a_hs_last",  hs_max, 967);
      chk("a_de_line",  de_cnt, 800);
      chk("a_sol_count", sol_n, 2);
      chk("a_sol_period", sol_i1 - sol_i0, 1056);
      chk("b_hs_width", bhs_cnt, 96);
      chk("b_hs_first", bhs_min, 656);
      chk("b_hs_last",  bhs_max, 751);

      // Reset in the middle of a line
      for (int i = 0; i < 501; i++) step();
      chk("a_pos_mid", longint'({ifa.qX, ifa.qY}), longint'({12'd500, 12'd2}));
      set_in(1'b0, 1'b0);
      step();
      chk("a_mid_reset", longint'({ifa.qX, ifa.qY, ifa.DE, ifa.HSYNC, ifa.VSYNC, ifa.SOL, ifa.SOF}),
          longint'({12'd1055, 12'd627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
      set_in(1'b1, 1'b1);
      step();
      chk("a_after_reset", longint'({ifa.qX, ifa.qY, ifa.DE, ifa.SOL, ifa.SOF}),
          longint'({12'd0, 12'd0, 1'b1, 1'b1, 1'b1}));

      // CE toggling at half rate
      rise_n = 0; rise0 = -1; rise1 = -1; strobe_viol = 0;
      prev_hs = ifa.HSYNC; prev_sol = ifa.SOL; prev_sof = ifa.SOF;
      for (int i = 0; i < 6000; i++) begin
         set_in(1'b1, (i % 2) == 1);
         step();
         if (ifa.HSYNC && !prev_hs) begin
            if (rise_n == 0) rise0 = i;
            if (rise_n == 1) rise1 = i;
            rise_n++;
         end
         if ((ifa.SOL && prev_sol) || (ifa.SOF && prev_sof)) strobe_viol++;
         prev_hs = ifa.HSYNC; prev_sol = ifa.SOL; prev_sof = ifa.SOF;
      end
      chk("half_hs_rises", rise_n, 3);
      chk("half_hs_period", rise1 - rise0, 2112);
      chk("half_strobe_width", strobe_viol, 0);
      chk("half_pos_end", longint'({ifa.qX, ifa.qY}), longint'({12'd888, 12'd2}));

      // Two full frames of the tiny mode
      do_reset();
      vs_bad = 0; vs_cnt = 0; vs_chg_viol = 0; sof_n = 0; sof_i0 = -1; sof_i1 = -1; cde_cnt = 0;
      prev_vs = ifc.VSYNC; prev_y = ifc.qY;
      set_in(1'b1, 1'b1);
      for (int i = 0; i < 112; i++) begin
         step();
         if ((ifc.VSYNC == 1'b0) != (ifc.qY == 4'd4 || ifc.qY == 4'd5)) vs_bad++;
         if (!ifc.VSYNC) vs_cnt++;
         if (ifc.VSYNC != prev_vs && ifc.qY == prev_y) vs_chg_viol++;
         if (ifc.DE) cde_cnt++;
         if (ifc.SOF) begin
            if (sof_n == 0) sof_i0 = i;
            if (sof_n == 1) sof_i1 = i;
            sof_n++;
         end
         prev_vs = ifc.VSYNC; prev_y = ifc.qY;
      end
      chk("c_vs_window", vs_bad, 0);
      chk("c_vs_cycles", vs_cnt, 32);
      chk("c_vs_on_line", vs_chg_viol, 0);
      chk("c_de_cycles", cde_cnt, 24);
      chk("c_sof_count", sof_n, 2);
      chk("c_sof_period", sof_i1 - sof_i0, 56);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("c_frame_cnt", longint'(ifc.qFRAME), 2);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
